stick_game_ctrl: RTL and testbench
==================================

// Module: stick_game_ctrl
// PURPOSE
// Game sequencer for the falling-stick reaction game. Owns the top-level FSM
// (idle/difficulty select, countdown, play, game over), schedules stick
// releases, animates per-stick y positions, scores catches and counts misses.
// Feeds the stick_y bus to the stick hit-test/renderer. Takes button pulses
// from the input_proc debouncers and a frame tick from the VGA timing.
// PARAMETERS
// NUM_STICKS    8    sticks managed, 2..8
// HOME_Y        300  resting top-edge y of every stick, pixels
// MISS_Y        600  top-edge y at which a falling stick counts as missed
// CD_FRAMES     60   frame ticks per countdown step
// RELEASE_BASE  120  release interval base, frames
// RELEASE_STEP  10   interval reduction per difficulty level, frames
// MAX_MISSES    3    misses that end the game, 1..15
// PORTS
// clk          in   1              system clock
// reset_n      in   1              synchronous reset, active low
// frame_tick   in   1              1-cycle pulse, once per frame
// btn_start    in   1              1-cycle pulse: start / return to idle
// btn_up       in   1              1-cycle pulse: difficulty +1 (idle only)
// btn_down     in   1              1-cycle pulse: difficulty -1 (idle only)
// catch_pulse  in   NUM_STICKS     1-cycle pulse per stick: catch attempt
// state        out  2              0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 OVER
// countdown    out  2              countdown digit 3..1; 0 outside COUNTDOWN
// difficulty   out  4              1..9
// score        out  8              catches, saturates at 255
// misses       out  4              missed sticks this game
// stick_y      out  NUM_STICKS*10  top-edge y, stick i at [10i+9:10i]
// stick_vis    out  NUM_STICKS     1 = stick drawn
// stick_fall   out  NUM_STICKS     1 = stick falling
// BEHAVIOUR
// - All outputs registered. Reset (reset_n=0 at posedge): state IDLE,
//   countdown 0, difficulty 1, score 0, misses 0, all stick_y=HOME_Y,
//   stick_vis all 1, stick_fall all 0, frame/interval counters 0, LFSR 8'hA5.
// - IDLE: btn_up/btn_down change difficulty, saturate at 9/1. btn_start ->
//   COUNTDOWN, countdown=3, frame counter 0; score/misses cleared, sticks home.
// - COUNTDOWN: every CD_FRAMES frame ticks countdown decrements; the tick that
//   would make it 0 -> PLAY, countdown=0, interval counter 0. Buttons ignored.
// - PLAY: interval I = RELEASE_BASE - difficulty*RELEASE_STEP frames. Interval
//   counter increments per frame_tick; on the tick it reaches I-1 it resets and
//   a release occurs: start index k = lfsr[2:0] mod NUM_STICKS; first stick j
//   scanning k, k+1, ... (mod NUM_STICKS) with vis=1 and fall=0 gets fall=1.
//   None eligible -> no release. LFSR (8-bit Galois, taps 0xB8) advances on
//   every frame_tick in any state, after index k is taken.
// - Each frame_tick in PLAY: every falling stick y += difficulty. If new
//   y >= MISS_Y: y=MISS_Y, fall=0, vis=0, misses+1.
// - catch_pulse[i] on any PLAY cycle with fall[i]=1: y[i]=HOME_Y, fall[i]=0,
//   score+1 (sat 255). Catch on a non-falling stick is ignored.
// - Same-cycle catch and frame_tick on one stick: catch wins, no advance, no
//   miss. Releases and catches on different sticks in one cycle both apply.
// - misses reaching MAX_MISSES, or all stick_vis 0 -> OVER on the next cycle.
//   OVER: sticks, score, misses frozen; catch pulses ignored.
// - btn_start only acts in IDLE and OVER (OVER -> IDLE, sticks home, vis=1,
//   score/misses kept for display until next start). Ignored in other states.
// - Multiple buttons same cycle in IDLE: btn_start wins; up+down cancel.
// - Outputs update the cycle after the causing input (1-cycle latency).
// TESTING
// 1 reset; up x3, down x1 -> difficulty 3; down x5 -> 1; up x12 -> 9.
// 2 diff 1, btn_start -> state 1, countdown 3; after 60 ticks 2; after 180
//   ticks state 2, countdown 0; btn_up in COUNTDOWN -> difficulty unchanged.
// 3 diff 1 in PLAY: 110th tick releases stick lfsr[2:0]; y 300->301/tick;
//   catch at y=350 -> y=300, fall=0, score=1.
// 4 diff 9, no catches: misses at y>=600 clamp y=600, vis=0; 3rd miss ->
//   state 3; further ticks/catches leave outputs frozen; btn_start -> state 0.
// 5 falling stick at y=599, catch_pulse and frame_tick same cycle -> caught,
//   misses unchanged, score+1.
// 6 reset_n=0 mid-PLAY with 2 sticks falling -> next cycle all reset values.

Source files
------------

// File: rtl/stick_game_ctrl.sv
// stick_game_ctrl: falling-stick game sequencer (FSM, release scheduling, stick animation, scoring)
module stick_game_ctrl #(
    parameter int NUM_STICKS   = 8,
    parameter int HOME_Y       = 300,
    parameter int MISS_Y       = 600,
    parameter int CD_FRAMES    = 60,
    parameter int RELEASE_BASE = 120,
    parameter int RELEASE_STEP = 10,
    parameter int MAX_MISSES   = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       frame_tick,
    input  logic                       btn_start,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic [NUM_STICKS-1:0]      catch_pulse,
    output logic [1:0]                 state,
    output logic [1:0]                 countdown,
    output logic [3:0]                 difficulty,
    output logic [7:0]                 score,
    output logic [3:0]                 misses,
    output logic [NUM_STICKS*10-1:0]   stick_y,
    output logic [NUM_STICKS-1:0]      stick_vis,
    output logic [NUM_STICKS-1:0]      stick_fall
);
    typedef enum logic [1:0] {S_IDLE, S_CD, S_PLAY, S_OVER} state_t;
    localparam logic [NUM_STICKS*10-1:0] HOME_ALL = {NUM_STICKS{10'(HOME_Y)}};
    state_t st;
    logic [15:0] frame_cnt, int_cnt, interval;
    logic [7:0] lfsr, lfsr_nx;
    logic rel_tick, found;
    logic [NUM_STICKS-1:0] rel_mask, fall_nx, vis_nx;
    logic [NUM_STICKS*10-1:0] y_nx;
    logic [3:0] n_catch, n_miss;
    logic [10:0] y_adv;
    logic [8:0] score_sum;
    logic [4:0] miss_sum;
    int j;
    assign state = st;
    // Next-frame stick update: release scan from the LFSR index, catches override the frame advance
    always_comb begin
        interval = 16'(RELEASE_BASE) - 16'(difficulty) * 16'(RELEASE_STEP);
        rel_tick = frame_tick && int_cnt == interval - 16'd1;
        lfsr_nx = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        rel_mask = '0;
        found = 1'b0;
        j = 0;
        for (int o = 0; o < NUM_STICKS; o++) begin
            j = (int'(lfsr[2:0]) + o) % NUM_STICKS;
            if (rel_tick && !found && stick_vis[j] && !stick_fall[j]) begin
                rel_mask[j] = 1'b1;
                found = 1'b1;
            end
        end
        y_nx = stick_y;
        fall_nx = stick_fall;
        vis_nx = stick_vis;
        n_catch = '0;
        n_miss = '0;
        y_adv = '0;
        for (int i = 0; i < NUM_STICKS; i++) begin
            if (catch_pulse[i] && stick_fall[i]) begin
                y_nx[10*i +: 10] = 10'(HOME_Y);
                fall_nx[i] = 1'b0;
                n_catch = n_catch + 4'd1;
            end else if (frame_tick && stick_fall[i]) begin
                y_adv = {1'b0, stick_y[10*i +: 10]} + 11'(difficulty);
                if (y_adv >= 11'(MISS_Y)) begin
                    y_nx[10*i +: 10] = 10'(MISS_Y);
                    fall_nx[i] = 1'b0;
                    vis_nx[i] = 1'b0;
                    n_miss = n_miss + 4'd1;
                end else begin
                    y_nx[10*i +: 10] = y_adv[9:0];
                end
            end
            if (rel_mask[i]) fall_nx[i] = 1'b1;
        end
        score_sum = {1'b0, score} + 9'(n_catch);
        miss_sum = {1'b0, misses} + 5'(n_miss);
    end
    // Game FSM with registered outputs; LFSR free-runs on every frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st <= S_IDLE;
            countdown <= '0;
            difficulty <= 4'd1;
            score <= '0;
            misses <= '0;
            stick_y <= HOME_ALL;
            stick_vis <= '1;
            stick_fall <= '0;
            frame_cnt <= '0;
            int_cnt <= '0;
            lfsr <= 8'hA5;
        end else begin
            if (frame_tick) lfsr <= lfsr_nx;
            case (st)
                S_IDLE: begin
                    if (btn_start) begin
                        st <= S_CD;
                        countdown <= 2'd3;
                        frame_cnt <= '0;
                        score <= '0;
                        misses <= '0;
                        stick_y <= HOME_ALL;
                        stick_vis <= '1;
                        stick_fall <= '0;
                    end else if (btn_up && !btn_down && difficulty != 4'd9) begin
                        difficulty <= difficulty + 4'd1;
                    end else if (btn_down && !btn_up && difficulty != 4'd1) begin
                        difficulty <= difficulty - 4'd1;
                    end
                end
                S_CD: begin
                    if (frame_tick) begin
                        if (frame_cnt == 16'(CD_FRAMES - 1)) begin
                            frame_cnt <= '0;
                            if (countdown == 2'd1) begin
                                st <= S_PLAY;
                                countdown <= '0;
                                int_cnt <= '0;
                            end else begin
                                countdown <= countdown - 2'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (misses >= 4'(MAX_MISSES) || stick_vis == '0) begin
                        st <= S_OVER;
                    end else begin
                        stick_y <= y_nx;
                        stick_fall <= fall_nx;
                        stick_vis <= vis_nx;
                        score <= score_sum[8] ? 8'hFF : score_sum[7:0];
                        misses <= miss_sum[4] ? 4'hF : miss_sum[3:0];
                        if (frame_tick) int_cnt <= rel_tick ? 16'd0 : int_cnt + 16'd1;
                    end
                end
                S_OVER: begin
                    if (btn_start) begin
                        st <= S_IDLE;
                        stick_y <= HOME_ALL;
                        stick_vis <= '1;
                        stick_fall <= '0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stick_game_ctrl.sv
// tb_stick_game_ctrl: directed scenario bench for stick_game_ctrl
module tb_stick_game_ctrl;
    localparam int N = 8;
    logic clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0;
    logic btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [N-1:0] catch_pulse = '0;
    logic [1:0] state, countdown;
    logic [3:0] difficulty, misses;
    logic [7:0] score;
    logic [N*10-1:0] stick_y;
    logic [N-1:0] stick_vis, stick_fall;
    int errors = 0, checks = 0;
    logic [7:0] m_lfsr = 8'hA5;
    localparam logic [N*10-1:0] HOME_ALL = {N{10'd300}};

    stick_game_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .btn_start(btn_start),
        .btn_up(btn_up), .btn_down(btn_down), .catch_pulse(catch_pulse), .state(state),
        .countdown(countdown), .difficulty(difficulty), .score(score), .misses(misses),
        .stick_y(stick_y), .stick_vis(stick_vis), .stick_fall(stick_fall)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic ft, input logic [N-1:0] cp, input logic bs, input logic bu, input logic bd);
        frame_tick = ft; catch_pulse = cp; btn_start = bs; btn_up = bu; btn_down = bd;
        @(posedge clk); #1;
        if (ft) m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
        frame_tick = 0; catch_pulse = '0; btn_start = 0; btn_up = 0; btn_down = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1, '0, 0, 0, 0);
            cyc(0, '0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        m_lfsr = 8'hA5;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL reset_countdown got=%0d exp=0", countdown); end
        checks++; if (difficulty !== 4'd1) begin errors++; $display("FAIL reset_difficulty got=%0d exp=1", difficulty); end
        checks++; if (score !== 8'd0 || misses !== 4'd0) begin errors++; $display("FAIL reset_score_misses got=%0d/%0d exp=0/0", score, misses); end
        checks++; if (stick_y !== HOME_ALL) begin errors++; $display("FAIL reset_stick_y got=%h exp=%h", stick_y, HOME_ALL); end
        checks++; if (stick_vis !== 8'hFF || stick_fall !== 8'h00) begin errors++; $display("FAIL reset_vis_fall got=%h/%h exp=ff/00", stick_vis, stick_fall); end
    endtask

    task automatic test_difficulty();
        repeat (3) cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 0, 1);
        checks++; if (difficulty !== 4'd3) begin errors++; $display("FAIL diff_up3_down1 got=%0d exp=3", difficulty); end
        repeat (5) cyc(0, '0, 0, 0, 1);
        checks++; if (difficulty !== 4'd1) begin errors++; $display("FAIL diff_floor got=%0d exp=1", difficulty); end
        repeat (12) cyc(0, '0, 0, 1, 0);
        checks++; if (difficulty !== 4'd9) begin errors++; $display("FAIL diff_ceiling got=%0d exp=9", difficulty); end
        cyc(0, '0, 0, 1, 1);
        cyc(0, '0, 0, 1, 1);
        checks++; if (difficulty !== 4'd9 || state !== 2'd0) begin errors++; $display("FAIL diff_up_down_cancel got=%0d st=%0d exp=9 st=0", difficulty, state); end
    endtask

    task automatic test_countdown();
        repeat (8) cyc(0, '0, 0, 0, 1);
        checks++; if (difficulty !== 4'd1) begin errors++; $display("FAIL cd_diff_setup got=%0d exp=1", difficulty); end
        cyc(0, '0, 1, 1, 0);
        checks++; if (state !== 2'd1 || countdown !== 2'd3 || difficulty !== 4'd1) begin errors++; $display("FAIL cd_start got st=%0d cd=%0d d=%0d exp st=1 cd=3 d=1", state, countdown, difficulty); end
        ticks(59);
        checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL cd_59_ticks got=%0d exp=3", countdown); end
        ticks(1);
        checks++; if (countdown !== 2'd2) begin errors++; $display("FAIL cd_60_ticks got=%0d exp=2", countdown); end
        cyc(0, '0, 0, 1, 0);
        checks++; if (difficulty !== 4'd1) begin errors++; $display("FAIL cd_btn_up_ignored got=%0d exp=1", difficulty); end
        cyc(0, '0, 1, 0, 0);
        checks++; if (state !== 2'd1 || countdown !== 2'd2) begin errors++; $display("FAIL cd_start_ignored got st=%0d cd=%0d exp st=1 cd=2", state, countdown); end
        ticks(119);
        checks++; if (state !== 2'd1 || countdown !== 2'd1) begin errors++; $display("FAIL cd_179_ticks got st=%0d cd=%0d exp st=1 cd=1", state, countdown); end
        ticks(1);
        checks++; if (state !== 2'd2 || countdown !== 2'd0) begin errors++; $display("FAIL cd_to_play got st=%0d cd=%0d exp st=2 cd=0", state, countdown); end
    endtask

    task automatic test_play_catch();
        int k;
        logic [N-1:0] mask;
        ticks(109);
        checks++; if (stick_fall !== 8'h00) begin errors++; $display("FAIL play_no_early_release got=%h exp=00", stick_fall); end
        k = int'(m_lfsr[2:0]);
        mask = N'(1) << k;
        ticks(1);
        checks++; if (stick_fall !== mask || stick_y[10*k +: 10] !== 10'd300) begin errors++; $display("FAIL play_release got fall=%h y=%0d exp fall=%h y=300", stick_fall, stick_y[10*k +: 10], mask); end
        ticks(1);
        checks++; if (stick_y[10*k +: 10] !== 10'd301) begin errors++; $display("FAIL play_first_step got=%0d exp=301", stick_y[10*k +: 10]); end
        ticks(49);
        checks++; if (stick_y[10*k +: 10] !== 10'd350) begin errors++; $display("FAIL play_y350 got=%0d exp=350", stick_y[10*k +: 10]); end
        cyc(0, mask, 0, 0, 0);
        checks++; if (stick_y[10*k +: 10] !== 10'd300 || stick_fall[k] !== 1'b0 || score !== 8'd1) begin errors++; $display("FAIL play_catch got y=%0d f=%0d s=%0d exp y=300 f=0 s=1", stick_y[10*k +: 10], stick_fall[k], score); end
        cyc(0, mask, 0, 0, 0);
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL play_catch_idle_stick got=%0d exp=1", score); end
    endtask

    task automatic test_same_cycle();
        int k;
        logic [N-1:0] mask;
        do_reset();
        cyc(0, '0, 1, 0, 0);
        ticks(180);
        ticks(109);
        k = int'(m_lfsr[2:0]);
        mask = N'(1) << k;
        ticks(300);
        checks++; if (stick_y[10*k +: 10] !== 10'd599 || stick_fall[k] !== 1'b1) begin errors++; $display("FAIL same_y599 got y=%0d f=%0d exp y=599 f=1", stick_y[10*k +: 10], stick_fall[k]); end
        cyc(1, mask, 0, 0, 0);
        checks++; if (stick_y[10*k +: 10] !== 10'd300 || stick_fall[k] !== 1'b0 || stick_vis[k] !== 1'b1) begin errors++; $display("FAIL same_catch_wins got y=%0d f=%0d v=%0d exp y=300 f=0 v=1", stick_y[10*k +: 10], stick_fall[k], stick_vis[k]); end
        checks++; if (score !== 8'd1 || misses !== 4'd0) begin errors++; $display("FAIL same_score_misses got s=%0d m=%0d exp s=1 m=0", score, misses); end
    endtask

    task automatic test_game_over();
        int k;
        logic [N*10-1:0] sy;
        logic [N-1:0] sf;
        do_reset();
        repeat (8) cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 1, 0, 0);
        ticks(180);
        ticks(29);
        k = int'(m_lfsr[2:0]);
        ticks(34);
        checks++; if (stick_y[10*k +: 10] !== 10'd597 || stick_vis[k] !== 1'b1) begin errors++; $display("FAIL over_y597 got y=%0d v=%0d exp y=597 v=1", stick_y[10*k +: 10], stick_vis[k]); end
        ticks(1);
        checks++; if (stick_y[10*k +: 10] !== 10'd600 || stick_vis[k] !== 1'b0 || stick_fall[k] !== 1'b0 || misses !== 4'd1) begin errors++; $display("FAIL over_first_miss got y=%0d v=%0d f=%0d m=%0d exp y=600 v=0 f=0 m=1", stick_y[10*k +: 10], stick_vis[k], stick_fall[k], misses); end
        ticks(59);
        checks++; if (misses !== 4'd2 || state !== 2'd2) begin errors++; $display("FAIL over_two_misses got m=%0d st=%0d exp m=2 st=2", misses, state); end
        cyc(1, '0, 0, 0, 0);
        checks++; if (misses !== 4'd3 || state !== 2'd2) begin errors++; $display("FAIL over_third_miss got m=%0d st=%0d exp m=3 st=2", misses, state); end
        cyc(0, '0, 0, 0, 0);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_enter got=%0d exp=3", state); end
        sy = stick_y;
        sf = stick_fall;
        ticks(5);
        cyc(1, '1, 0, 1, 0);
        checks++; if (stick_y !== sy || stick_fall !== sf || misses !== 4'd3 || score !== 8'd0 || state !== 2'd3) begin errors++; $display("FAIL over_frozen got y=%h f=%h m=%0d s=%0d st=%0d exp y=%h f=%h m=3 s=0 st=3", stick_y, stick_fall, misses, score, state, sy, sf); end
        cyc(0, '0, 1, 0, 0);
        checks++; if (state !== 2'd0 || stick_vis !== 8'hFF || stick_fall !== 8'h00 || stick_y !== HOME_ALL || misses !== 4'd3) begin errors++; $display("FAIL over_to_idle got st=%0d v=%h f=%h m=%0d exp st=0 v=ff f=00 m=3", state, stick_vis, stick_fall, misses); end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        repeat (8) cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 1, 0, 0);
        ticks(180);
        ticks(60);
        checks++; if ($countones(stick_fall) != 2 || state !== 2'd2) begin errors++; $display("FAIL mid_two_falling got f=%h st=%0d exp two bits st=2", stick_fall, state); end
        reset_n = 0;
        @(posedge clk); #1;
        checks++; if (state !== 2'd0 || countdown !== 2'd0 || difficulty !== 4'd1 || score !== 8'd0 || misses !== 4'd0) begin errors++; $display("FAIL mid_reset_regs got st=%0d cd=%0d d=%0d s=%0d m=%0d exp 0/0/1/0/0", state, countdown, difficulty, score, misses); end
        checks++; if (stick_y !== HOME_ALL || stick_vis !== 8'hFF || stick_fall !== 8'h00) begin errors++; $display("FAIL mid_reset_sticks got y=%h v=%h f=%h", stick_y, stick_vis, stick_fall); end
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_difficulty();
        test_countdown();
        test_play_catch();
        test_same_cycle();
        test_game_over();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
